// File: rtl/alu_writeback.sv
// ALU result write-back queue: in-order FIFO toward the register file
// with youngest-match forwarding over pending entries.
module alu_writeback #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic                       alu_rd_en,
  input  logic [4:0]                 alu_rd_addr,
  input  logic [XLEN-1:0]            alu_rd_data,
  input  logic                       flush,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [4:0]                 wb_addr,
  output logic [XLEN-1:0]            wb_data,
  input  logic [4:0]                 fwd_rs1_addr,
  input  logic [4:0]                 fwd_rs2_addr,
  output logic                       fwd_rs1_hit,
  output logic                       fwd_rs2_hit,
  output logic [XLEN-1:0]            fwd_rs1_data,
  output logic [XLEN-1:0]            fwd_rs2_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   idx;
  logic [4:0]      addr_q [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic            push;
  logic            pop;

  assign alu_ready = count < CW'(DEPTH);
  assign wb_valid  = count != '0;
  assign wb_addr   = addr_q[head];
  assign wb_data   = data_q[head];

  // Results with no register target are accepted but never queued.
  assign push = alu_valid && alu_ready && alu_rd_en
             && (alu_rd_addr != 5'd0) && !flush;
  assign pop  = wb_valid && wb_ready && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (push) begin
      addr_q[tail] <= alu_rd_addr;
      data_q[tail] <= alu_rd_data;
    end
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    idx          = '0;
    fwd_rs1_hit  = 1'b0;
    fwd_rs2_hit  = 1'b0;
    fwd_rs1_data = '0;
    fwd_rs2_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (CW'(k) < count) begin
        if (fwd_rs1_addr != 5'd0 && addr_q[idx] == fwd_rs1_addr) begin
          fwd_rs1_hit  = 1'b1;
          fwd_rs1_data = data_q[idx];
        end
        if (fwd_rs2_addr != 5'd0 && addr_q[idx] == fwd_rs2_addr) begin
          fwd_rs2_hit  = 1'b1;
          fwd_rs2_data = data_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Scoreboard bench for alu_writeback: directed pushes feed an expected
// queue, a negedge monitor checks every write-back and occupancy.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic        alu_rd_en;
  logic [4:0]  alu_rd_addr;
  logic [31:0] alu_rd_data;
  logic        flush;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  fwd_rs1_addr;
  logic [4:0]  fwd_rs2_addr;
  logic        fwd_rs1_hit;
  logic        fwd_rs2_hit;
  logic [31:0] fwd_rs1_data;
  logic [31:0] fwd_rs2_data;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;
  logic [36:0] sb [$];

  always #5 clk = ~clk;

  alu_writeback #(.XLEN(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_rd_en(alu_rd_en), .alu_rd_addr(alu_rd_addr),
    .alu_rd_data(alu_rd_data), .flush(flush),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data),
    .fwd_rs1_addr(fwd_rs1_addr), .fwd_rs2_addr(fwd_rs2_addr),
    .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit),
    .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data),
    .count(count)
  );

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every write-back handshake.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("occupancy", 64'(count), 64'(sb.size()));
      if (!flush && wb_valid && wb_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_wb", 64'(wb_valid), 64'd0);
        end else begin
          logic [36:0] e;
          e = sb.pop_front();
          chk("wb_addr", 64'(wb_addr), 64'(e[36:32]));
          chk("wb_data", 64'(wb_data), 64'(e[31:0]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic en, input logic [4:0] a,
                      input logic [31:0] d);
    int n = 0;
    alu_valid   = 1'b1;
    alu_rd_en   = en;
    alu_rd_addr = a;
    alu_rd_data = d;
    while (!alu_ready && n < 20) begin
      tick();
      n++;
    end
    if (!alu_ready) chk("send_timeout", 64'(alu_ready), 64'd1);
    tick();
    if (en && a != 5'd0) sb.push_back({a, d});
    alu_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    wb_ready = 1'b1;
    while (count != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("drain_count", 64'(count), 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    alu_valid = 1'b0;
    alu_rd_en = 1'b0;
    alu_rd_addr = '0;
    alu_rd_data = '0;
    flush = 1'b0;
    wb_ready = 1'b0;
    fwd_rs1_addr = 5'd5;
    fwd_rs2_addr = 5'd0;
    #12;
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_alu_ready", 64'(alu_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_wb_addr", 64'(wb_addr), 64'd0);
    chk("rst_wb_data", 64'(wb_data), 64'd0);
    chk("rst_fwd1_hit", 64'(fwd_rs1_hit), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Single write
    wb_ready = 1'b1;
    send(1'b1, 5'd5, 32'h1234);
    chk("single_valid", 64'(wb_valid), 64'd1);
    chk("single_addr", 64'(wb_addr), 64'd5);
    chk("single_data", 64'(wb_data), 64'h1234);
    tick();
    chk("single_count", 64'(count), 64'd0);

    // Fill with backpressure
    wb_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(1'b1, 5'(i), 32'(i * 16));
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(alu_ready), 64'd0);
    tick();
    chk("stall_addr", 64'(wb_addr), 64'd1);
    chk("stall_data", 64'(wb_data), 64'h10);
    wb_ready = 1'b1;
    tick();
    chk("after_pop_ready", 64'(alu_ready), 64'd1);
    chk("after_pop_count", 64'(count), 64'd3);
    drain();

    // Forwarding, youngest match
    wb_ready = 1'b0;
    send(1'b1, 5'd7, 32'hA);
    send(1'b1, 5'd7, 32'hB);
    send(1'b1, 5'd3, 32'hC);
    fwd_rs1_addr = 5'd7;
    fwd_rs2_addr = 5'd0;
    #1;
    chk("fwd1_hit", 64'(fwd_rs1_hit), 64'd1);
    chk("fwd1_data", 64'(fwd_rs1_data), 64'hB);
    chk("fwd2_hit_x0", 64'(fwd_rs2_hit), 64'd0);
    chk("fwd2_data_x0", 64'(fwd_rs2_data), 64'd0);
    fwd_rs2_addr = 5'd3;
    alu_valid = 1'b1;
    alu_rd_en = 1'b1;
    alu_rd_addr = 5'd9;
    alu_rd_data = 32'h99;
    fwd_rs1_addr = 5'd9;
    #1;
    chk("fwd2_hit_x3", 64'(fwd_rs2_hit), 64'd1);
    chk("fwd2_data_x3", 64'(fwd_rs2_data), 64'hC);
    chk("fwd_no_bypass", 64'(fwd_rs1_hit), 64'd0);
    alu_valid = 1'b0;
    drain();
    fwd_rs1_addr = 5'd7;
    #1;
    chk("fwd_popped_miss", 64'(fwd_rs1_hit), 64'd0);

    // Drop rule
    send(1'b0, 5'd4, 32'hDEAD);
    chk("drop_en_count", 64'(count), 64'd0);
    send(1'b1, 5'd0, 32'hBEEF);
    chk("drop_x0_count", 64'(count), 64'd0);
    chk("drop_wb_valid", 64'(wb_valid), 64'd0);

    // Flush with simultaneous push and pop
    wb_ready = 1'b0;
    send(1'b1, 5'd1, 32'h11);
    send(1'b1, 5'd2, 32'h22);
    send(1'b1, 5'd6, 32'h33);
    chk("pre_flush_count", 64'(count), 64'd3);
    flush = 1'b1;
    wb_ready = 1'b1;
    alu_valid = 1'b1;
    alu_rd_en = 1'b1;
    alu_rd_addr = 5'd8;
    alu_rd_data = 32'h99;
    tick();
    sb.delete();
    flush = 1'b0;
    alu_valid = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_wb_valid", 64'(wb_valid), 64'd0);
    repeat (3) tick();

    // Async reset mid-stream
    wb_ready = 1'b0;
    send(1'b1, 5'd12, 32'h77);
    send(1'b1, 5'd13, 32'h88);
    chk("pre_rst_count", 64'(count), 64'd2);
    #2;
    rst = 1'b0;
    sb.delete();
    #1;
    fwd_rs1_addr = 5'd12;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_wb_valid", 64'(wb_valid), 64'd0);
    chk("arst_alu_ready", 64'(alu_ready), 64'd1);
    chk("arst_wb_addr", 64'(wb_addr), 64'd0);
    chk("arst_wb_data", 64'(wb_data), 64'd0);
    chk("arst_fwd_hit", 64'(fwd_rs1_hit), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    wb_ready = 1'b1;
    repeat (3) tick();
    chk("post_rst_valid", 64'(wb_valid), 64'd0);
    send(1'b1, 5'd9, 32'h55);
    chk("post_rst_accept", 64'(wb_addr), 64'd9);
    drain();
    tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 Parameter XLEN, default 32, datapath width of result words.
REQ-002 Parameter DEPTH, default 4, number of pending-result entries; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 alu_valid  input  1  ALU result presented this cycle.
REQ-006 alu_ready  output  1  block can accept a result this cycle.
REQ-007 alu_rd_en  input  1  result targets a register.
REQ-008 alu_rd_addr  input  5  destination register index.
REQ-009 alu_rd_data  input  XLEN  result value.
REQ-010 flush  input  1  discard all pending results.
REQ-011 wb_valid  output  1  head entry presented to register-file write port.
REQ-012 wb_ready  input  1  register file accepts head entry.
REQ-013 wb_addr  output  5  head entry destination.
REQ-014 wb_data  output  XLEN  head entry value.
REQ-015 fwd_rs1_addr, fwd_rs2_addr  input  5 each  source indices queried for forwarding.
REQ-016 fwd_rs1_hit, fwd_rs2_hit  output  1 each  a pending entry matches.
REQ-017 fwd_rs1_data, fwd_rs2_data  output  XLEN each  value of matching entry.
REQ-018 count  output  log2(DEPTH)+1  number of pending entries.

Function
REQ-019 Block SHALL be a FIFO of DEPTH entries {addr, data} with registered head/tail pointers and occupancy counter.
REQ-020 alu_ready SHALL equal (count < DEPTH) and SHALL NOT depend combinationally on wb_ready.
REQ-021 Accept occurs when alu_valid and alu_ready are both 1 on a clock edge.
REQ-022 Accepted results with alu_rd_en = 0 or alu_rd_addr = 0 SHALL be consumed and dropped: no entry written, count unchanged.
REQ-023 Other accepted results SHALL be written at tail; tail advances modulo DEPTH.
REQ-024 wb_valid SHALL equal (count != 0); wb_addr/wb_data SHALL show head entry, driven from storage, not from ALU inputs.
REQ-025 Minimum latency accept -> wb_valid SHALL be exactly 1 cycle.
REQ-026 Pop occurs when wb_valid and wb_ready are both 1; head advances modulo DEPTH.
REQ-027 Simultaneous push and pop SHALL leave count unchanged and both pointers advance.
REQ-028 wb_valid=1 with wb_ready=0 SHALL hold wb_addr/wb_data stable until pop or flush.
REQ-029 Entries SHALL leave in acceptance order; no reordering, no merging of same-address entries.
REQ-030 Forwarding SHALL be combinational over valid entries only: hit = some valid entry addr equals query addr and query addr != 0.
REQ-031 On multiple matches, fwd data SHALL be the youngest (most recently accepted) matching entry.
REQ-032 Query addr 0 or no match: hit = 0, data = 0.
REQ-033 Current-cycle ALU inputs SHALL NOT participate in forwarding.
REQ-034 flush = 1 at an edge SHALL set count, head and tail to 0; push and pop that cycle SHALL be ignored (no write, no pop).
REQ-035 At count = DEPTH, alu_ready = 0; a pop that cycle frees space only from the next cycle.
REQ-036 At count = 0, wb_ready SHALL be ignored and count SHALL NOT underflow.

Reset
REQ-037 rst = 0 SHALL immediately (asynchronously) set count, head and tail to 0; wb_valid = 0, alu_ready = 1, fwd hits 0.
REQ-038 Entry storage SHALL reset to 0, so wb_addr = 0 and wb_data = 0 while empty after reset.
REQ-039 Reset asserted mid-operation SHALL discard all pending entries; no write-back of them after release.
REQ-040 Deassertion SHALL be synchronised to clk; first accept possible on first edge with rst = 1.

Verification
REQ-041 Single write: accept (x5, 0x1234) with wb_ready = 1 -> next cycle wb_valid = 1, wb_addr = 5, wb_data = 0x1234; popped that edge, count returns 0.
REQ-042 Fill/backpressure: wb_ready = 0, push x1..x4 with data 0x10..0x40 -> count = 4, alu_ready = 0; raise wb_ready -> pops in order x1..x4, alu_ready = 1 after first pop.
REQ-043 Forwarding: pending (x7, 0xA), (x7, 0xB), (x3, 0xC); query rs1 = 7, rs2 = 0 -> fwd_rs1_hit = 1, data 0xB; fwd_rs2_hit = 0, data 0.
REQ-044 Drop rule: accept rd_en = 0 and rd_addr = 0 results -> count stays 0, wb_valid never rises.
REQ-045 Flush with simultaneous push and pop at count = 3 -> next cycle count = 0, wb_valid = 0, pushed value never written back.
REQ-046 Async reset mid-stream: rst low between edges with count = 2 -> outputs reset immediately; after release wb_valid = 0 until new accept.
